// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and sizing helpers for the clocked adder family
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int steps(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int cnt_w(input int width, input int chunk);
    return $clog2(width / chunk + 1);
  endfunction
  function automatic bit chunk_ok(input int width, input int chunk);
    return chunk >= 1 && width >= 2 && width % chunk == 0;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational ripple of CHUNK full-adder cells (x, y, ci -> s, co)
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK:0] k;
  assign k[0] = ci;
  assign co = k[CHUNK];
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i] = x[i] ^ y[i] ^ k[i];
    assign k[i+1] = (x[i] & y[i]) | (k[i] & (x[i] ^ y[i]));
  end
endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds a+b+cin CHUNK bits per clock with start/busy/done handshake; SERIAL_ADDER_OVF_EN adds signed-overflow output ovf
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int STEPS = steps(WIDTH, CHUNK);
  localparam int CW = cnt_w(WIDTH, CHUNK);
  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end
  state_t state, nxt;
  logic [WIDTH-1:0] ra, rb;
  logic c;
  logic [CW-1:0] cnt;
  logic [CHUNK-1:0] cs;
  logic cc, acc, last;
  logic [WIDTH+CHUNK-1:0] sw;
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .x (ra[CHUNK-1:0]),
    .y (rb[CHUNK-1:0]),
    .ci(c),
    .s (cs),
    .co(cc)
  );
  assign busy = state == RUN;
  assign done = state == DONE;
  assign acc = start && state != RUN;
  assign last = busy && cnt == CW'(STEPS - 1);
  assign sw = {cs, sum};
  always_comb nxt = acc ? RUN : busy ? (last ? DONE : RUN) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        ra <= a;
        rb <= b;
        c <= cin;
        cnt <= '0;
      end else if (busy) begin
        ra <= ra >> CHUNK;
        rb <= rb >> CHUNK;
        c <= cc;
        cnt <= cnt + 1'b1;
        sum <= sw[WIDTH+CHUNK-1:CHUNK];
        cout <= cc;
      end
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  // carry into the MSB is recovered from the MSB cell's own inputs and sum bit
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (last) ovf <= ra[CHUNK-1] ^ rb[CHUNK-1] ^ cs[CHUNK-1] ^ cc;
  end
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at CHUNK = 1, 4 and 8
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic cin = 1'b0;
  logic start_v [3];
  logic busy_v [3];
  logic done_v [3];
  logic cout_v [3];
  logic [7:0] sum_v [3];
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_v [3];
`endif
  int n = 0;
  int errs = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf_v[0])
`endif
  );
  serial_adder #(.WIDTH(8), .CHUNK(4)) u4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf_v[1])
`endif
  );
  serial_adder #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf_v[2])
`endif
  );
  task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
    n++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic run(input int k, input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                     input int lat, input logic [7:0] es, input logic ec, input bit b2b);
    if (!b2b) @(negedge clk);
    a = ta;
    b = tb2;
    cin = tc;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int i = 0; i < lat; i++) begin
      chk($sformatf("u%0d busy step %0d", k, i), 9'(busy_v[k]), 9'd1);
      chk($sformatf("u%0d no done step %0d", k, i), 9'(done_v[k]), 9'd0);
      @(negedge clk);
    end
    chk($sformatf("u%0d done", k), 9'(done_v[k]), 9'd1);
    chk($sformatf("u%0d busy low in done", k), 9'(busy_v[k]), 9'd0);
    chk($sformatf("u%0d {cout,sum} %h+%h+%b", k, ta, tb2, tc), {cout_v[k], sum_v[k]}, {ec, es});
  endtask
  initial begin
    foreach (start_v[i]) start_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d reset busy", k), 9'(busy_v[k]), 9'd0);
      chk($sformatf("u%0d reset done", k), 9'(done_v[k]), 9'd0);
      chk($sformatf("u%0d reset sum/cout", k), {cout_v[k], sum_v[k]}, 9'd0);
    end
    rst = 1'b0;
    run(0, 8'h0F, 8'h01, 1'b0, 8, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("u0 done falls", 9'(done_v[0]), 9'd0);
    chk("u0 result held", {cout_v[0], sum_v[0]}, 9'h010);
    run(0, 8'hFF, 8'h01, 1'b0, 8, 8'h00, 1'b1, 1'b0);
    run(0, 8'hFF, 8'hFF, 1'b1, 8, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h55; b = 8'h55; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; a = 8'h00; b = 8'h00;
    chk("u0 busy after ignored start", 9'(busy_v[0]), 9'd1);
    repeat (5) @(negedge clk);
    chk("u0 done with ignored start", 9'(done_v[0]), 9'd1);
    chk("u0 result ignores run start", {cout_v[0], sum_v[0]}, 9'h010);
    @(negedge clk);
    chk("u0 no extra done 1", 9'(done_v[0]), 9'd0);
    chk("u0 idle after ignored start", 9'(busy_v[0]), 9'd0);
    @(negedge clk);
    chk("u0 no extra done 2", 9'(done_v[0]), 9'd0);
    a = 8'h0F; b = 8'h01; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("u0 abort busy", 9'(busy_v[0]), 9'd0);
    chk("u0 abort done", 9'(done_v[0]), 9'd0);
    chk("u0 abort sum/cout", {cout_v[0], sum_v[0]}, 9'd0);
    run(0, 8'h03, 8'h04, 1'b0, 8, 8'h07, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; start_v[0] = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    rst = 1'b0; start_v[0] = 1'b0;
    chk("u0 rst beats start busy", 9'(busy_v[0]), 9'd0);
    @(negedge clk);
    chk("u0 start dropped under rst", 9'(busy_v[0]), 9'd0);
    chk("u0 sum after rst+start", {cout_v[0], sum_v[0]}, 9'd0);
    run(1, 8'h9A, 8'h7C, 1'b1, 2, 8'h17, 1'b1, 1'b0);
    run(2, 8'h9A, 8'h7C, 1'b1, 1, 8'h17, 1'b1, 1'b0);
    run(2, 8'hA5, 8'h5A, 1'b1, 1, 8'h00, 1'b1, 1'b1);
    run(1, 8'h00, 8'h00, 1'b0, 2, 8'h00, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    run(0, 8'h7F, 8'h01, 1'b0, 8, 8'h80, 1'b0, 1'b0);
    chk("u0 ovf 7F+01", 9'(ovf_v[0]), 9'd1);
    run(0, 8'h80, 8'hFF, 1'b0, 8, 8'h7F, 1'b1, 1'b0);
    chk("u0 ovf 80+FF", 9'(ovf_v[0]), 9'd1);
    run(0, 8'h10, 8'h20, 1'b0, 8, 8'h30, 1'b0, 1'b0);
    chk("u0 ovf 10+20", 9'(ovf_v[0]), 9'd0);
    run(1, 8'h7F, 8'h01, 1'b0, 2, 8'h80, 1'b0, 1'b0);
    chk("u1 ovf 7F+01", 9'(ovf_v[1]), 9'd1);
    run(2, 8'h80, 8'hFF, 1'b0, 1, 8'h7F, 1'b1, 1'b0);
    chk("u2 ovf 80+FF", 9'(ovf_v[2]), 9'd1);
    run(2, 8'hFF, 8'hFF, 1'b0, 1, 8'hFE, 1'b1, 1'b0);
    chk("u2 ovf FF+FF", 9'(ovf_v[2]), 9'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
